mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter that sits behind the system bridge as a bus responder, alongside the timers. It uses the same register-port shape as the timers (word address, write enable, write data, read data, IRQ). The CPU writes bytes into a small FIFO, and the block serialises them 8N1 on `txd`. A level interrupt is raised when the transmitter has drained.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: FIFO entries; power of two, at least 2.
- `DIV_RESET`, default 16'd434: reset value of DIVISOR, in clock cycles per bit.

Ports:
- `clk`, in, 1: system clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state immediately.
- `Addr`, in, [31:2]: word address; only `Addr[3:2]` is decoded.
- `WE`, in, 1: register write strobe, sampled at the rising edge.
- `Din`, in, 32: write data.
- `Dout`, out, 32: read data; combinational from `Addr[3:2]`; reset value 0 except where noted below.
- `IRQ`, out, 1: level interrupt; reset value 0.
- `txd`, out, 1: serial output, registered; reset value 1 (idle high).

## Operation
Register map, selected by `Addr[3:2]`:
- 0 DATA
  - Write: push `Din[7:0]` into the FIFO.
  - Read: returns 0.
- 1 STATUS (read)
  - Bit 0: busy (FSM not in IDLE).
  - Bit 1: FIFO full.
  - Bit 2: FIFO empty.
  - Bit 3: overflow (sticky).
  - Bits [11:8]: FIFO count.
  - Write to STATUS (any data) clears overflow.
  - Reset read value: 0x4.
- 2 CTRL, read/write
  - Bit 0: enable.
  - Bit 1: irq_en.
  - Other bits read as 0.
  - Reset value 0.
- 3 DIVISOR, read/write, bits [15:0].
  - Reset value `DIV_RESET`.
  - A value of 0 is treated as 1.

FIFO rules:
- A push while the FIFO is full is dropped and sets overflow.
- A push and a pop in the same cycle on a full FIFO: the push is accepted and the count is unchanged.

FSM states: IDLE, START, DATA, [PARITY], STOP.
- IDLE goes to START when enable=1 and the FIFO is non-empty; pop the head into the shift register and load the bit counter.
- START drives `txd`=0 for one bit time, then DATA.
- DATA shifts out 8 bits LSB first, one bit time each, then STOP (or PARITY when compiled in).
- STOP drives `txd`=1 for one bit time, then IDLE.

Clearing enable mid-frame:
- The current frame completes.
- No further pops occur; FIFO contents are retained.

`IRQ` = irq_en & FIFO empty & FSM in IDLE, as a registered output.

## Timing
- Bit time: `max(DIVISOR,1)` cycles, timed by a down-counter reloaded at each bit boundary.
- DIVISOR writes take effect at the next bit boundary; a bit already in progress is never stretched or cut.
- Write-to-line latency: DATA write at edge N into an empty FIFO, with enable=1 and FSM idle:
  - Count=1 visible after edge N.
  - Pop, START entry, and `txd` falling all occur at edge N+1.
- Frame length: 10 bit times (11 with parity).
- Back-to-back bytes: the STOP→IDLE→START transition adds exactly one cycle between the end of STOP and the next start bit.
- `IRQ` asserts one cycle after the FSM returns to IDLE with the FIFO empty. It deasserts one cycle after a DATA push or an irq_en clear.
- Reset mid-frame: `txd`=1 and the FIFO is emptied immediately; no partial frame resumes.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state present; sends even parity over the 8 data bits after bit 7.
  - CTRL bit 2 = parity_odd selects odd parity.
- Not defined:
  - No PARITY state; CTRL bit 2 reads 0.
  - Frame is strictly 8N1.

## Structure
- Shared constants package/header (the existing constants include):
  - Register offsets (`UART_TX_DATA`/`STATUS`/`CTRL`/`DIV` word indices).
  - FSM state encodings.
  - STATUS/CTRL bit positions.
- One sub-module `uart_tx_fifo`: synchronous FIFO with push, pop, full, empty and count, asynchronous active-high reset, depth from `FIFO_DEPTH`.
- Baud counter and FSM live in the top.

## Test plan
- Reset → `txd`=1, `IRQ`=0, STATUS=0x4, DIVISOR=434.
- DIVISOR=4, CTRL=1, write DATA=0x55 → `txd` sequence 0,1,0,1,0,1,0,1,0,1, each held exactly 4 cycles; start bit begins one cycle after the write edge.
- DIVISOR=2, CTRL=0, write 9 bytes with FIFO_DEPTH=8 → STATUS count=8, full=1, overflow=1. Write STATUS → overflow=0. Set enable → 8 frames emitted in order.
- CTRL=3, DIVISOR=1, write 0xA0 → `IRQ` stays 0 during the frame and rises one cycle after STOP ends. Write DATA → `IRQ` drops the next cycle.
- Clear enable during DATA of the first of 2 queued bytes → first frame completes, second stays queued (count=1), `txd` remains 1.
- Assert reset mid-frame → `txd`=1 asynchronously, count=0; with `UART_TX_PARITY_EN`, 0x07 sends parity bit 1 (even), 0 with parity_odd.

Source files
------------

// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register word
// indices, FSM encodings, STATUS/CTRL bit positions and the bit-time helper.
package mmio_uart_tx_pkg;

    localparam logic [1:0] UART_TX_DATA   = 2'd0;
    localparam logic [1:0] UART_TX_STATUS = 2'd1;
    localparam logic [1:0] UART_TX_CTRL   = 2'd2;
    localparam logic [1:0] UART_TX_DIV    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_COUNT_LSB = 8;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_PAR_ODD  = 2;

    // Down-counter reload for one bit time; a divisor of 0 behaves as 1.
    function automatic logic [15:0] bit_reload(input logic [15:0] div);
        return (div == 16'd0) ? 16'd0 : div - 16'd1;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter; a pop in the same cycle
// lets a push into a full FIFO through.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with byte FIFO and drain interrupt.
// Optional even/odd parity bit is compiled in with UART_TX_PARITY_EN.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        txd
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    uart_state_t   state, state_n;
    logic [15:0]   divisor, cnt, cnt_n, reload;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n, fifo_dout;
    logic          enable, irq_en, overflow;
    logic          txd_n, pop, push, bit_end;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [3:0]    count4;
    logic          unused_bits;
`ifdef UART_TX_PARITY_EN
    logic          par_odd, par_bit;
`endif

    assign push        = WE && (Addr[3:2] == UART_TX_DATA);
    assign reload      = bit_reload(divisor);
    assign bit_end     = (cnt == 16'd0);
    assign count4      = 4'(fifo_count);
    assign unused_bits = ^{Addr[31:4], Din[31:16]};

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (Din[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable   <= 1'b0;
            irq_en   <= 1'b0;
            divisor  <= DIV_RESET;
            overflow <= 1'b0;
        end else if (WE) begin
            case (Addr[3:2])
                UART_TX_STATUS: overflow <= 1'b0;
                UART_TX_CTRL: begin
                    enable <= Din[CTRL_EN];
                    irq_en <= Din[CTRL_IRQ_EN];
                end
                UART_TX_DIV:    divisor <= Din[15:0];
                default:        if (fifo_full && !pop) overflow <= 1'b1;
            endcase
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                  par_odd <= 1'b0;
        else if (WE && Addr[3:2] == UART_TX_CTRL)   par_odd <= Din[CTRL_PAR_ODD];
    end

    // Parity is fixed for the frame at the moment the byte is popped.
    always_ff @(posedge clk) begin
        if (pop) par_bit <= (^fifo_dout) ^ par_odd;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            txd     <= 1'b1;
            IRQ     <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            txd     <= txd_n;
            IRQ     <= irq_en && fifo_empty && (state == ST_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_n;
    end

    // Next-state logic; the divisor is sampled only when a bit time starts.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && !fifo_empty) begin
                    pop     = 1'b1;
                    shreg_n = fifo_dout;
                    cnt_n   = reload;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bit_idx_n = 3'd0;
                    cnt_n     = reload;
                    state_n   = ST_DATA;
                end else cnt_n = cnt - 16'd1;
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_n = reload;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        shreg_n   = {1'b0, shreg[7:1]};
                    end
                end else cnt_n = cnt - 16'd1;
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    cnt_n   = reload;
                    state_n = ST_STOP;
                end else cnt_n = cnt - 16'd1;
            end
`endif
            ST_STOP: begin
                if (bit_end) state_n = ST_IDLE;
                else         cnt_n   = cnt - 16'd1;
            end
            default: state_n = ST_IDLE;
        endcase

        case (state_n)
            ST_START: txd_n = 1'b0;
            ST_DATA:  txd_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_n = par_bit_src();
`endif
            default:  txd_n = 1'b1;
        endcase
    end

`ifdef UART_TX_PARITY_EN
    function automatic logic par_bit_src();
        return par_bit;
    endfunction
`endif

    always_comb begin
        Dout = 32'd0;
        case (Addr[3:2])
            UART_TX_STATUS: begin
                Dout[STAT_BUSY]              = (state != ST_IDLE);
                Dout[STAT_FULL]              = fifo_full;
                Dout[STAT_EMPTY]             = fifo_empty;
                Dout[STAT_OVF]               = overflow;
                Dout[STAT_COUNT_LSB +: 4]    = count4;
            end
            UART_TX_CTRL: begin
                Dout[CTRL_EN]     = enable;
                Dout[CTRL_IRQ_EN] = irq_en;
`ifdef UART_TX_PARITY_EN
                Dout[CTRL_PAR_ODD] = par_odd;
`else
                Dout[CTRL_PAR_ODD] = 1'b0;
`endif
            end
            UART_TX_DIV: Dout[15:0] = divisor;
            default:     ;
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register map, frame timing, FIFO
// overflow, drain interrupt, enable clear mid-frame and async reset.
module tb_mmio_uart_tx;
    import mmio_uart_tx_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:2] Addr = '0;
    logic        WE = 1'b0;
    logic [31:0] Din = '0;
    logic [31:0] Dout;
    logic        IRQ;
    logic        txd;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mmio_uart_tx #(.FIFO_DEPTH(8), .DIV_RESET(16'd434)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ),
        .txd   (txd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        Addr = {28'd0, a};
        Din  = d;
        WE   = 1'b1;
        @(negedge clk);
        WE   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        Addr = {28'd0, a};
        #1;
        d = Dout;
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    // Waits for a start bit, then samples the first cycle of each data bit.
    task automatic rx_byte(input int d, output logic [7:0] b, output int t0);
        int n;
        n  = 0;
        b  = 8'h00;
        while (txd !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rx_start_seen", 32'(n < 2000), 32'd1);
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            repeat (d) @(negedge clk);
            b[i] = txd;
        end
        repeat (d) @(negedge clk);
        check("rx_stop_bit", 32'(txd), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [7:0]  b;
        int          t0, tprev;

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_txd", 32'(txd), 32'd1);
        check("reset_irq", 32'(IRQ), 32'd0);
        rd(UART_TX_STATUS, r); check("reset_status", r, 32'h4);
        rd(UART_TX_DIV, r);    check("reset_div", r, 32'd434);
        rd(UART_TX_CTRL, r);   check("reset_ctrl", r, 32'h0);
        rd(UART_TX_DATA, r);   check("data_read_zero", r, 32'h0);

        // 0x55 at 4 cycles per bit, start bit one cycle after the write edge
        wr(UART_TX_DIV, 32'd4);
        wr(UART_TX_CTRL, 32'h1);
        wr(UART_TX_DATA, 32'h55);
        check("wr55_txd_idle", 32'(txd), 32'd1);
        rd(UART_TX_STATUS, r); check("wr55_count1", r, 32'h100);
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            check($sformatf("f55_cyc%0d", t), 32'(txd), 32'(frame_bit(8'h55, (t - 1) / 4)));
        end
        @(negedge clk);
        check("f55_after_txd", 32'(txd), 32'd1);
        rd(UART_TX_STATUS, r); check("f55_after_status", r, 32'h4);

        // Overflow and ordered drain
        wr(UART_TX_DIV, 32'd2);
        wr(UART_TX_CTRL, 32'h0);
        for (int i = 0; i < 9; i++) wr(UART_TX_DATA, 32'(8'h11 * (i + 1)));
        rd(UART_TX_STATUS, r); check("ovf_status", r, 32'h80A);
        wr(UART_TX_STATUS, 32'h0);
        rd(UART_TX_STATUS, r); check("ovf_cleared", r, 32'h802);
        wr(UART_TX_CTRL, 32'h1);
        tprev = 0;
        for (int k = 0; k < 8; k++) begin
            rx_byte(2, b, t0);
            check($sformatf("drain_byte%0d", k), 32'(b), 32'(8'h11 * (k + 1)));
            if (k > 0) check($sformatf("drain_gap%0d", k), 32'(t0 - tprev), 32'd21);
            tprev = t0;
        end
        repeat (3) @(negedge clk);
        rd(UART_TX_STATUS, r); check("drain_empty", r, 32'h4);

        // Drain interrupt timing
        wr(UART_TX_DIV, 32'd1);
        wr(UART_TX_CTRL, 32'h3);
        check("irq_en_lag", 32'(IRQ), 32'd0);
        @(negedge clk);
        check("irq_idle_high", 32'(IRQ), 32'd1);
        wr(UART_TX_DATA, 32'hA0);
        check("irq_push_lag", 32'(IRQ), 32'd1);
        for (int t = 1; t <= 11; t++) begin
            @(negedge clk);
            check($sformatf("irq_frame_cyc%0d", t), 32'(IRQ), 32'd0);
        end
        @(negedge clk);
        check("irq_after_stop", 32'(IRQ), 32'd1);
        wr(UART_TX_DATA, 32'h3C);
        check("irq_push2_lag", 32'(IRQ), 32'd1);
        @(negedge clk);
        check("irq_push2_drop", 32'(IRQ), 32'd0);
        repeat (10) @(negedge clk);
        @(negedge clk);
        check("irq_after_stop2", 32'(IRQ), 32'd1);
        wr(UART_TX_CTRL, 32'h1);
        check("irq_clr_lag", 32'(IRQ), 32'd1);
        @(negedge clk);
        check("irq_clr_drop", 32'(IRQ), 32'd0);

        // Enable cleared during DATA of the first of two queued bytes
        wr(UART_TX_CTRL, 32'h0);
        wr(UART_TX_DIV, 32'd4);
        wr(UART_TX_DATA, 32'hC3);
        wr(UART_TX_DATA, 32'h5A);
        wr(UART_TX_CTRL, 32'h1);
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (t == 8) begin
                Addr = {28'd0, UART_TX_CTRL};
                Din  = 32'h0;
                WE   = 1'b1;
            end
            if (t == 9) WE = 1'b0;
            check($sformatf("fC3_cyc%0d", t), 32'(txd), 32'(frame_bit(8'hC3, (t - 1) / 4)));
        end
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            check($sformatf("hold_idle%0d", t), 32'(txd), 32'd1);
        end
        rd(UART_TX_STATUS, r); check("hold_count1", r, 32'h100);

        // Asynchronous reset mid-frame
        wr(UART_TX_CTRL, 32'h1);
        @(negedge clk);
        check("rst_pre_start", 32'(txd), 32'd0);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check("rst_async_txd", 32'(txd), 32'd1);
        rd(UART_TX_STATUS, r); check("rst_async_status", r, 32'h4);
        rd(UART_TX_DIV, r);    check("rst_async_div", r, 32'd434);
        @(negedge clk);
        reset = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            check($sformatf("rst_idle%0d", t), 32'(txd), 32'd1);
        end
        rd(UART_TX_STATUS, r); check("rst_after_status", r, 32'h4);
        rd(UART_TX_CTRL, r);   check("rst_after_ctrl", r, 32'h0);

`ifdef UART_TX_PARITY_EN
        wr(UART_TX_DIV, 32'd2);
        wr(UART_TX_CTRL, 32'h1);
        wr(UART_TX_DATA, 32'h07);
        @(negedge clk);
        check("par_even_start", 32'(txd), 32'd0);
        repeat (18) @(negedge clk);
        check("par_even_bit", 32'(txd), 32'd1);
        repeat (6) @(negedge clk);
        wr(UART_TX_CTRL, 32'h5);
        rd(UART_TX_CTRL, r); check("par_ctrl_read", r, 32'h5);
        wr(UART_TX_DATA, 32'h07);
        @(negedge clk);
        check("par_odd_start", 32'(txd), 32'd0);
        repeat (18) @(negedge clk);
        check("par_odd_bit", 32'(txd), 32'd0);
        repeat (6) @(negedge clk);
`else
        wr(UART_TX_CTRL, 32'h7);
        rd(UART_TX_CTRL, r); check("ctrl_bit2_zero", r, 32'h3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
